// File: rtl/stream_register_ff.sv
// rtl/stream_register_ff.sv - W-bit flop with asynchronous reset, synchronous clear and load enable
module stream_register_ff #(
    parameter int unsigned    W           = 1,
    parameter logic [W-1:0]   RESET_VALUE = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Clear wins over load; clear returns the flop to its reset value.
    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = RESET_VALUE;
        end else if (en_i) begin
            q_d = d_i;
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= RESET_VALUE;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/stream_register.sv
// rtl/stream_register.sv - single-entry elastic valid/ready pipeline register (assertions: STREAM_REGISTER_ASSERT_EN)
module stream_register #(
    parameter type T = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic testmode_i,
    input  logic valid_i,
    output logic ready_o,
    input  T     data_i,
    output logic valid_o,
    input  logic ready_i,
    output T     data_o
);

    localparam int unsigned W = $bits(T);

    logic         valid_q;
    logic [W-1:0] data_q;
    logic         load_en;

    // Test mode only matters for a clock-gated variant of this register.
    logic unused_testmode;
    assign unused_testmode = testmode_i;

    // Accept whenever the slot is empty or is being drained this cycle;
    // deliberately independent of valid_i.
    assign ready_o = ready_i | ~valid_q;
    assign load_en = valid_i & ready_o;

    // Full flag: clear has priority, otherwise it follows valid_i whenever
    // the slot can take a word (covers empty fill and pop+push replace).
    stream_register_ff #(
        .W           (1),
        .RESET_VALUE (1'b0)
    ) u_valid_ff (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (clr_i),
        .en_i   (ready_o),
        .d_i    (valid_i),
        .q_o    (valid_q)
    );

    // Payload: only loads on an input handshake; clear leaves it untouched.
    stream_register_ff #(
        .W           (W),
        .RESET_VALUE ('0)
    ) u_data_ff (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (1'b0),
        .en_i   (load_en),
        .d_i    (data_i),
        .q_o    (data_q)
    );

    assign valid_o = valid_q;
    assign data_o  = T'(data_q);

`ifdef STREAM_REGISTER_ASSERT_EN
    // Upstream may not withdraw a word before it is accepted.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        (valid_i && !ready_o) |=> valid_i)
        else $error("stream_register: valid_i dropped before handshake");

    // Upstream word must not change while it waits.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        (valid_i && !ready_o) |=> $stable(data_i))
        else $error("stream_register: data_i changed before handshake");

    // Our own output is held until the downstream takes it (unless cleared).
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        (valid_o && !ready_i && !clr_i) |=> (valid_o && $stable(data_o)))
        else $error("stream_register: output changed before handshake");

    // Control inputs must be known once out of reset.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        !$isunknown({valid_i, ready_i, clr_i}))
        else $error("stream_register: X on control input");
`endif

endmodule

// File: tb/tb_stream_register.sv
// tb/tb_stream_register.sv - scoreboard bench for stream_register with T = logic [7:0]
module tb_stream_register;

    typedef logic [7:0] byte_t;

    logic  clk_i = 1'b0;
    logic  rst_ni;
    logic  clr_i;
    logic  testmode_i;
    logic  valid_i;
    logic  ready_o;
    byte_t data_i;
    logic  valid_o;
    logic  ready_i;
    byte_t data_o;

    int    total = 0;
    int    bad   = 0;
    byte_t exp_q[$];
    logic  m_full = 1'b0;

    stream_register #(.T(byte_t)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (clr_i),
        .testmode_i (testmode_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .data_i     (data_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .data_o     (data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // One cycle of stimulus; the reference model advances at the edge using
    // the values the DUT sampled there.
    task automatic step(input logic v, input byte_t d, input logic r, input logic c);
        valid_i = v;
        data_i  = d;
        ready_i = r;
        clr_i   = c;
        @(posedge clk_i);
        if (c) begin
            if (m_full && !r && exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
            m_full = 1'b0;
        end else if (r || !m_full) begin
            if (v) exp_q.push_back(d);
            m_full = v;
        end
        #1;
    endtask

    // Monitor: mid-cycle, compare handshake signals with the model and pop
    // the scoreboard whenever the downstream takes a word.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            check("ready_o", {31'd0, ready_o}, {31'd0, ready_i || !m_full});
            check("valid_o", {31'd0, valid_o}, {31'd0, m_full});
            if (valid_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {24'd0, data_o}, 32'hFFFF_FFFF);
                end else begin
                    check("data_o", {24'd0, data_o}, {24'd0, exp_q[0]});
                    if (ready_i) exp_q.pop_front();
                end
            end
        end
    end

    initial begin
        rst_ni     = 1'b0;
        clr_i      = 1'b0;
        testmode_i = 1'b0;
        valid_i    = 1'b0;
        ready_i    = 1'b0;
        data_i     = 8'h00;
        #2;
        check("reset_valid_o", {31'd0, valid_o}, 32'd0);
        check("reset_data_o", {24'd0, data_o}, 32'd0);
        check("reset_ready_o", {31'd0, ready_o}, 32'd1);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // Asynchronous reset while holding 0xA5.
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        #2 rst_ni = 1'b0;
        exp_q.delete();
        m_full = 1'b0;
        #1;
        check("async_rst_valid_o", {31'd0, valid_o}, 32'd0);
        check("async_rst_data_o", {24'd0, data_o}, 32'd0);
        check("async_rst_ready_o", {31'd0, ready_o}, 32'd1);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // Single transfer.
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Back-pressure: 0x22 waits five cycles behind 0x11.
        step(1'b1, 8'h11, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Streaming 0x01..0x10 at full rate.
        for (int i = 1; i <= 16; i++) step(1'b1, byte_t'(i), 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Clear drops the held 0x77 and the concurrent 0x88.
        step(1'b1, 8'h77, 1'b0, 1'b0);
        step(1'b1, 8'h88, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Simultaneous pop of 0x55 and push of 0x66.
        step(1'b1, 8'h55, 1'b0, 1'b0);
        step(1'b1, 8'h66, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        check("final_valid_o", {31'd0, valid_o}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
